// File: rtl/vga_pixel_source.sv
// Pixel source for the VGA timing controller: 4x-upscaled palette framebuffer
// with a rectangle-fill engine. Optional macro FB_WRITE_BLANK_EN restricts fill writes to blanking.
module vga_pixel_source #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [11:0] d_out,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_x1,
  input  logic [6:0]  cmd_y0,
  input  logic [6:0]  cmd_y1,
  input  logic [3:0]  cmd_color,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_data,
  output logic        busy
);

  localparam int unsigned CELLS = FB_W * FB_H;
  localparam int          AW    = $clog2(CELLS);
  localparam logic [7:0]  X_MAX = 8'(FB_W - 1);
  localparam logic [6:0]  Y_MAX = 7'(FB_H - 1);
  localparam logic [8:0]  ROW_LIM = 9'(FB_H);
  localparam logic [9:0]  COL_LIM = 10'(FB_W);

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_nx;
  logic [3:0]    fb [CELLS];
  logic [11:0]   pal [16];

  logic [7:0]    x0_q, x1_q, cur_x;
  logic [6:0]    y1_q, cur_y;
  logic [3:0]    color_q;
  logic [7:0]    x1_c;
  logic [6:0]    y1_c;
  logic          degenerate, accept, step, last, fb_we;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [8:0]    row_cell;
  logic [9:0]    col_cell;
  logic          in_range;

  assign x1_c       = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
  assign y1_c       = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  assign degenerate = (cmd_x0 > x1_c) || (cmd_y0 > y1_c);
  assign accept     = cmd_valid && cmd_ready;
  assign last       = (cur_x == x1_q) && (cur_y == y1_q);
  assign busy       = ~cmd_ready;

`ifdef FB_WRITE_BLANK_EN
  // Fill writes advance only while the controller is blanking.
  assign step = (state == FILL) && rdn;
`else
  assign step = (state == FILL);
`endif

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    fb_we     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !degenerate) state_nx = FILL;
      end
      FILL: begin
        if (step) begin
          fb_we = 1'b1;
          if (last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
    end else if (accept) begin
      x0_q    <= cmd_x0;
      x1_q    <= x1_c;
      y1_q    <= y1_c;
      color_q <= cmd_color;
      cur_x   <= cmd_x0;
      cur_y   <= cmd_y0;
    end else if (fb_we && !last) begin
      if (cur_x == x1_q) begin
        cur_x <= x0_q;
        cur_y <= cur_y + 7'd1;
      end else begin
        cur_x <= cur_x + 8'd1;
      end
    end
  end

  assign wr_idx = AW'(cur_y) * AW'(FB_W) + AW'(cur_x);

  // Framebuffer is deliberately not reset; contents survive clrn.
  always_ff @(posedge vga_clk) begin
    if (fb_we) fb[wr_idx] <= color_q;
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  assign row_cell = row_addr >> SCALE_LOG2;
  assign col_cell = col_addr >> SCALE_LOG2;
  assign in_range = (row_cell < ROW_LIM) && (col_cell < COL_LIM);
  assign rd_idx   = in_range ? (AW'(row_cell) * AW'(FB_W) + AW'(col_cell)) : '0;

  always_comb begin
    d_out = '0;
    if (!rdn && in_range) d_out = pal[fb[rd_idx]];
  end

endmodule

// File: tb/tb_vga_pixel_source.sv
// Self-checking bench for vga_pixel_source: queue-based fill model, directed cases and random traffic.
module tb_vga_pixel_source;

  localparam int W = 160;
  localparam int H = 120;

  logic        vga_clk = 1'b0;
  logic        clrn = 1'b1;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic        rdn = 1'b1;
  logic [11:0] d_out;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [6:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [3:0]  cmd_color = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [11:0] pal_data = '0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit hold = 1'b1;
  bit rnd = 1'b0;
  bit fb_init_done = 1'b0;

  vga_pixel_source #(.FB_W(W), .FB_H(H), .SCALE_LOG2(2)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr),
    .rdn(rdn), .d_out(d_out), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .busy(busy)
  );

  always #20 vga_clk = ~vga_clk;

  // Reference model: a fill is the list of cells still to be written.
  logic [3:0]  m_fb [W*H];
  logic [11:0] m_pal [16];
  int          q[$];
  logic [3:0]  m_col;
  bit          m_idle;
  bit          m_wr_ok;
  int          ex1, ey1;

  always @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      q.delete();
      for (int i = 0; i < 16; i++) m_pal[i] = {3{4'(i)}};
    end else begin
      m_idle = (q.size() == 0);
`ifdef FB_WRITE_BLANK_EN
      m_wr_ok = rdn;
`else
      m_wr_ok = 1'b1;
`endif
      if (pal_we) m_pal[pal_addr] = pal_data;
      if (!m_idle && m_wr_ok) m_fb[q.pop_front()] = m_col;
      if (m_idle && cmd_valid) begin
        ex1 = (int'(cmd_x1) > W - 1) ? W - 1 : int'(cmd_x1);
        ey1 = (int'(cmd_y1) > H - 1) ? H - 1 : int'(cmd_y1);
        m_col = cmd_color;
        for (int y = int'(cmd_y0); y <= ey1; y++)
          for (int x = int'(cmd_x0); x <= ex1; x++)
            q.push_back(y * W + x);
      end
    end
  end

  function automatic logic [11:0] exp_pix(input int r, input int c, input logic rd);
    if (rd) return 12'h000;
    if ((r >> 2) >= H || (c >> 2) >= W) return 12'h000;
    return m_pal[m_fb[(r >> 2) * W + (c >> 2)]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (clrn) begin
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, q.size() == 0});
      chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      if (rdn || fb_init_done)
        chk("d_out", {20'd0, d_out}, {20'd0, exp_pix(int'(row_addr), int'(col_addr), rdn)});
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (!hold) begin
      rdn = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) begin
        row_addr = 9'($urandom_range(0, 511));
        col_addr = 10'($urandom_range(0, 1023));
      end else begin
        row_addr = 9'($urandom_range(0, 479));
        col_addr = 10'($urandom_range(0, 639));
      end
    end
    if (rnd) begin
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_x0    = 8'($urandom_range(0, 165));
      cmd_x1    = 8'(int'(cmd_x0) + $urandom_range(0, 6) - 1);
      cmd_y0    = 7'($urandom_range(0, 125));
      cmd_y1    = 7'(int'(cmd_y0) + $urandom_range(0, 4) - 1);
      cmd_color = 4'($urandom);
      pal_we    = $urandom_range(0, 7) == 0;
      pal_addr  = 4'($urandom);
      pal_data  = 12'($urandom);
    end
  endtask

  task automatic issue(input int x0, input int y0, input int x1, input int y1, input int c);
    cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_x1 = 8'(x1); cmd_y1 = 7'(y1);
    cmd_color = 4'(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_x0 = 8'($urandom); cmd_x1 = 8'($urandom);
    cmd_y0 = 7'($urandom); cmd_y1 = 7'($urandom); cmd_color = 4'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 25000) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input int r, input int c, input logic [11:0] exp, input string nm);
    row_addr = 9'(r); col_addr = 10'(c); rdn = 1'b0;
    #1;
    chk(nm, {20'd0, d_out}, {20'd0, exp});
  endtask

  initial begin
    int n;
    #5 clrn = 1'b0;
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dout_blank", {20'd0, d_out}, 32'd0);
    repeat (2) @(posedge vga_clk);
    #1 clrn = 1'b1;

    issue(0, 0, 159, 119, 3);
    wait_idle(n);
    chk("init_fill_cycles", n, 32'd19200);
    fb_init_done = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(0, 0, 0, 0, i);
      wait_idle(n);
      rd(0, 0, {3{4'(i)}}, "gray_sweep");
      rdn = 1'b1;
      #1 chk("gray_sweep_blank", {20'd0, d_out}, 32'd0);
    end

    pal_addr = 4'd5; pal_data = 12'hABC; pal_we = 1'b1;
    tick();
    pal_we = 1'b0;
    issue(2, 3, 4, 4, 5);
    wait_idle(n);
    chk("rect_busy_cycles", n, 32'd6);
    for (int r = 12; r <= 19; r++)
      for (int c = 8; c <= 19; c++) rd(r, c, 12'hABC, "rect_pixels");
    rd(12, 7, 12'h333, "rect_left_neighbour");
    rdn = 1'b1;

    issue(10, 0, 9, 0, 1);
    chk("degen_ready", {31'd0, cmd_ready}, 32'd1);
    wait_idle(n);
    chk("degen_cycles", n, 32'd0);
    rd(0, 40, 12'h333, "degen_untouched");
    rdn = 1'b1;

    issue(150, 110, 255, 127, 2);
    wait_idle(n);
    chk("clamp_cycles", n, 32'd100);
    rd(479, 639, 12'h222, "clamp_corner");
    rd(0, 0, 12'hFFF, "clamp_origin_kept");
    rd(436, 596, 12'h333, "clamp_outside");
    rdn = 1'b1;

    issue(20, 50, 35, 50, 7);
    repeat (3) tick();
    clrn = 1'b0;
    #1;
    chk("midfill_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midfill_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    clrn = 1'b1;
    tick();
    rd(200, 80, 12'h777, "midfill_first");
    rd(200, 88, 12'h777, "midfill_third");
    rd(200, 92, 12'h333, "midfill_fourth_old");
    rd(200, 143, 12'h333, "midfill_last_old");
    rd(12, 8, 12'h555, "midfill_pal_gray");
    rdn = 1'b1;

`ifdef FB_WRITE_BLANK_EN
    rdn = 1'b0;
    row_addr = 9'd240; col_addr = 10'd160;
    issue(40, 60, 43, 60, 9);
    for (int i = 0; i < 20; i++) begin
      chk("blank_stall_ready", {31'd0, cmd_ready}, 32'd0);
      chk("blank_stall_pixel", {20'd0, d_out}, 32'h333);
      tick();
    end
    rdn = 1'b1;
    wait_idle(n);
    chk("blank_resume_cycles", n, 32'd4);
    rd(240, 172, 12'h999, "blank_done_pixel");
    rdn = 1'b1;
`endif

    hold = 1'b0;
    rnd = 1'b1;
    repeat (4000) tick();
    rnd = 1'b0;
    cmd_valid = 1'b0;
    pal_we = 1'b0;
    hold = 1'b1;
    rdn = 1'b1;
    wait_idle(n);
    chk("drain_bounded", {31'd0, n < 25000}, 32'd1);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_source.md
# vga_pixel_source

Pixel source that sits directly upstream of the VGA timing controller. It holds a 160×120 framebuffer of 4-bit palette indices, upscaled 4× to 640×480, and a 16-entry 12-bit palette. It answers the controller's `row_addr`/`col_addr`/`rdn` with a `bbbb_gggg_rrrr` pixel in the same cycle. Game logic draws into it through a rectangle-fill command port with a valid/ready handshake and a palette write port.

## Interface
Parameters:
- `FB_W`, default 160: framebuffer width in cells.
- `FB_H`, default 120: framebuffer height in cells.
- `SCALE_LOG2`, default 2: screen pixels per cell edge = 2^SCALE_LOG2.

Ports (clock and reset first):
- `vga_clk`, in, 1: single clock, 25 MHz.
- `clrn`, in, 1: reset; asynchronous, active-low.
- `row_addr`, in, 9: pixel row, 0–479.
- `col_addr`, in, 10: pixel column, 0–639.
- `rdn`, in, 1: read strobe, active-low; high during blanking.
- `d_out`, out, 12: pixel colour `bbbb_gggg_rrrr`; combinational.
- `cmd_valid`, in, 1: fill command valid.
- `cmd_ready`, out, 1: fill engine idle, command can be accepted.
- `cmd_x0`, `cmd_x1`, in, 8 each: inclusive column bounds, in cells.
- `cmd_y0`, `cmd_y1`, in, 7 each: inclusive row bounds, in cells.
- `cmd_color`, in, 4: palette index to fill with.
- `pal_we`, in, 1: palette write enable.
- `pal_addr`, in, 4: palette entry to write.
- `pal_data`, in, 12: palette colour to write.
- `busy`, out, 1: equals `~cmd_ready`.

## Operation
- Read path, fully combinational:
  - cell = fb[`row_addr` >> SCALE_LOG2][`col_addr` >> SCALE_LOG2].
  - `d_out` = palette[cell] when `rdn`=0, else 12'h000.
  - If the shifted address is ≥ FB_W or ≥ FB_H, `d_out` = 0.
- Framebuffer contents are not reset. After power-up they are undefined until a fill covers them.
- Palette resets to grayscale: entry i = {i,i,i}. `pal_we` writes at the clock edge.
- Fill FSM states: IDLE, FILL.
  - IDLE: `cmd_ready`=1. Handshake completes on an edge where `cmd_valid`=1 and `cmd_ready`=1. At that edge the coordinates and colour are latched.
  - Clamping at accept: x1 is clamped to FB_W−1, y1 to FB_H−1.
  - If x0 > x1 or y0 > y1 after clamping, the command is consumed with zero writes and the FSM stays in IDLE.
  - Otherwise the FSM enters FILL with cursor = (x0, y0).
  - FILL: each write cycle writes `cmd_color` to fb[cursor]. Cursor advances in raster order: x increments; on x = x1 it wraps to x0 and y increments.
  - After the write at (x1, y1), the FSM returns to IDLE.
- Inputs are ignored outside the handshake. `cmd_*` may change freely while `cmd_ready`=0.
- Palette writes are independent of the FSM and may occur during FILL.

## Timing
- Reset values: FSM = IDLE, `cmd_ready`=1, `busy`=0, cursor = 0, palette = grayscale. `d_out` follows the read path (0 while `rdn`=1).
- Read latency is 0 cycles: `d_out` is valid in the cycle in which the address is presented. This matches the controller, which registers its input on the next edge.
- Command accepted at edge E0 with an N-cell valid rectangle:
  - Writes occur at edges E1..EN.
  - `cmd_ready`=0 during cycles E0..EN. It is 1 again after EN, so a new accept can happen at EN+1 at the earliest.
- Degenerate command: `cmd_ready` stays 1, so back-to-back accepts are possible.
- Simultaneous write and read of the same cell or palette entry: the read returns the old value. The new value is visible from the next cycle.
- Reset asserted mid-FILL: the FSM is forced to IDLE immediately and the remaining writes are dropped. Cells already written keep their new value.

## Configuration
- `FB_WRITE_BLANK_EN`:
  - Defined: during FILL, a write and cursor advance happen only on cycles where `rdn`=1 (blanking). On cycles where `rdn`=0 the engine stalls with state held. This gives tear-free drawing, and a fill of N cells takes N blanking cycles.
  - Undefined: one write every cycle, regardless of `rdn`.

## Test plan
- Reset, then sweep `pal_addr`=0..15 with `rdn`=0 and fb previously filled with index i: `d_out` = {i,i,i}. With `rdn`=1, `d_out` = 12'h000.
- Fill (x0=2, y0=3, x1=4, y1=4, color=5), with palette[5]=12'hABC written first:
  - `cmd_ready` is low for exactly 6 cycles.
  - Reading row_addr=12..19, col_addr=8..19 returns 12'hABC; col_addr=7 returns the old colour.
- Fill (10, 0, 9, 0, 1), i.e. x0 > x1: zero cycles busy, `cmd_ready` never drops, fb unchanged.
- Fill (150, 110, 255, 127, 2): clamped to 10×10 = 100 writes. Read at row 479, col 639 returns palette[2]. No write escapes bounds; cell (0,0) is unchanged.
- Assert `clrn` after 3 cycles of a 16-cell fill: `cmd_ready`=1 at once. The first 3 cells are new, the rest old, and the palette is back to grayscale.
- With `FB_WRITE_BLANK_EN`, hold `rdn`=0 for 20 cycles during a 4-cell fill: no cells change. After `rdn`=1, it completes in 4 cycles.
